// File: rtl/imem_loader_if.sv
// Handshake and write-bus bundle between imem_loader and its environment:
// the incoming program byte stream and the instruction-memory write port.
interface imem_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;

  // Loader side: consumes bytes and drives the instruction-memory write port.
  modport master (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output mem_we,
    output mem_addr,
    output mem_data
  );

  // Environment side: byte source plus instruction memory.
  modport slave (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_data
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: takes a length-prefixed big-endian byte stream and writes it into
// instruction memory while holding the CPU. Optional trailing XOR checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          hold_cpu,
  output logic          done,
  output logic          error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_WRITE, S_CSUM, S_DONE} state_t;
  localparam state_t S_FINISH = S_CSUM;
`else
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_WRITE, S_DONE} state_t;
  localparam state_t S_FINISH = S_DONE;
`endif

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] word_count_q, word_count_d;
  logic [15:0] word_index_q, word_index_d;
  logic [23:0] word_buf_q, word_buf_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        rx_ready_w;
  logic        accept;
  logic [15:0] hdr_count;
  logic [15:0] next_index;

  // Handshake and status outputs are pure functions of the current state.
  assign rx_ready_w = (state_q == S_HDR) || (state_q == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                      || (state_q == S_CSUM)
`endif
                      ;
  assign accept     = bus.rx_valid && rx_ready_w;
  assign hdr_count  = {word_count_q[15:8], bus.rx_data};
  assign next_index = word_index_q + 16'd1;

  assign bus.rx_ready = rx_ready_w;
  assign bus.mem_we   = (state_q == S_WRITE);
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign hold_cpu     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done         = done_q;
  assign error        = error_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    word_count_d = word_count_q;
    word_index_d = word_index_q;
    word_buf_d   = word_buf_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    done_d       = done_q;
    error_d      = error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_HDR;
          byte_cnt_d   = 2'd0;
          word_count_d = 16'd0;
          word_index_d = 16'd0;
          done_d       = 1'b0;
          error_d      = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d       = 8'd0;
`endif
        end
      end

      S_HDR: begin
        if (accept) begin
          if (byte_cnt_q == 2'd0) begin
            word_count_d = {bus.rx_data, 8'h00};
            byte_cnt_d   = 2'd1;
          end else begin
            word_count_d = hdr_count;
            byte_cnt_d   = 2'd0;
            if (hdr_count == 16'd0) begin
              state_d = S_FINISH;
            end else if ({16'd0, hdr_count} > MAX_WORDS) begin
              error_d = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          // byte_cnt wraps 3 -> 0 on its own, ready for the next word.
          byte_cnt_d = byte_cnt_q + 2'd1;
          word_buf_d = {word_buf_q[15:0], bus.rx_data};
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ bus.rx_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            mem_data_d = {word_buf_q, bus.rx_data};
            mem_addr_d = BASE_ADDR + {14'd0, word_index_q, 2'b00};
            state_d    = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        word_index_d = next_index;
        state_d      = (next_index == word_count_q) ? S_FINISH : S_DATA;
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) begin
          if (bus.rx_data != csum_q) error_d = 1'b1;
          state_d = S_DONE;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase

    // done rises on entry to DONE and stays until the next start clears it.
    if (state_d == S_DONE) done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= 2'd0;
      word_count_q <= 16'd0;
      word_index_q <= 16'd0;
      word_buf_q   <= 24'd0;
      mem_addr_q   <= 32'd0;
      mem_data_q   <= 32'd0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_count_q <= word_count_d;
      word_index_q <= word_index_d;
      word_buf_q   <= word_buf_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      done_q       <= done_d;
      error_q      <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized program loads compared
// against a word-list model of the expected memory writes and status flags.
`timescale 1ns/1ps
module tb_imem_loader;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int unsigned MAXW = 1024;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic hold_cpu;
  logic done;
  logic error;

  imem_loader_if bus ();

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .hold_cpu (hold_cpu),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  logic [31:0] prog[$];

  // Memory-side monitor: every cycle with mem_we high is one write.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      obs_addr.push_back(bus.mem_addr);
      obs_data.push_back(bus.mem_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  function automatic int rand_gap(input int lo, input int hi);
    return int'($urandom_range(hi, lo));
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit taken;
    int waited;
    bus.rx_valid = 1'b0;
    repeat (gap) step();
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    taken  = 1'b0;
    waited = 0;
    while (!taken && waited < 40) begin
      @(negedge clk);
      taken = (bus.rx_ready === 1'b1);
      step();
      waited++;
    end
    bus.rx_valid = 1'b0;
    if (!taken) check("byte_accept_timeout", 32'(taken), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check("done_within_budget", 32'(done), 32'd1);
  endtask

  task automatic fill_random(input int n);
    prog.delete();
    for (int i = 0; i < n; i++) prog.push_back($urandom);
  endtask

  // Full load of prog[0..count-1] behind header `count`; expectations derived from the load rules.
  task automatic run_load(input logic [15:0] count, input int lo, input int hi,
                          input bit bad_csum, input bit poke_start, input int budget);
    logic [7:0]  x;
    logic [7:0]  b;
    logic [31:0] word;
    bit          valid;
    bit          exp_err;
    int          nexp;
    int          cnt;
    obs_addr.delete();
    obs_data.delete();
    x   = 8'd0;
    cnt = int'(count);
    do_start();
    check("hold_after_start", 32'(hold_cpu), 32'd1);
    check("done_cleared", 32'(done), 32'd0);
    check("error_cleared", 32'(error), 32'd0);
    send_byte(count[15:8], rand_gap(lo, hi));
    send_byte(count[7:0], rand_gap(lo, hi));
    valid = (cnt != 0) && (32'(cnt) <= MAXW);
    if (valid) begin
      for (int w = 0; w < cnt; w++) begin
        word = prog[w];
        for (int k = 3; k >= 0; k--) begin
          b = word[8*k +: 8];
          x ^= b;
          send_byte(b, rand_gap(lo, hi));
          if (poke_start && w == 0 && k == 2) begin
            start = 1'b1;
            step();
            start = 1'b0;
          end
        end
      end
    end
    exp_err = (32'(cnt) > MAXW);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (32'(cnt) <= MAXW) begin
      send_byte(x ^ {7'd0, bad_csum}, rand_gap(lo, hi));
      exp_err = bad_csum;
    end
`endif
    wait_done(budget);
    nexp = valid ? cnt : 0;
    check("hold_released", 32'(hold_cpu), 32'd0);
    check("rx_ready_in_done", 32'(bus.rx_ready), 32'd0);
    check("mem_we_in_done", 32'(bus.mem_we), 32'd0);
    check("error_flag", 32'(error), 32'(exp_err));
    check("write_count", 32'(obs_addr.size()), 32'(nexp));
    for (int i = 0; i < nexp && i < obs_addr.size(); i++) begin
      check("write_addr", obs_addr[i], BASE + 32'(i) * 32'd4);
      check("write_data", obs_data[i], prog[i]);
    end
    if (nexp > 0) begin
      check("addr_held", bus.mem_addr, BASE + 32'(nexp - 1) * 32'd4);
      check("data_held", bus.mem_data, prog[nexp - 1]);
    end
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) step();
    check("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_data", bus.mem_data, 32'd0);
    check("rst_hold_cpu", 32'(hold_cpu), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset = 1'b0;
    step();

    // Single word 0xDEADBEEF.
    prog.delete();
    prog.push_back(32'hDEAD_BEEF);
    run_load(16'd1, 0, 0, 1'b0, 1'b0, 20);

    // Three words with rx_valid toggling every other cycle.
    prog.delete();
    prog.push_back(32'h1111_1111);
    prog.push_back(32'h2222_2222);
    prog.push_back(32'h3333_3333);
    run_load(16'd3, 1, 1, 1'b0, 1'b0, 20);

    // Oversize header: error, no writes; then zero-length header.
    run_load(16'h0401, 0, 1, 1'b0, 1'b0, 20);
    run_load(16'h0000, 0, 0, 1'b0, 1'b0, 3);

    // Randomized programs and gaps; one load gets a stray start mid-word.
    for (int r = 0; r < 6; r++) begin
      fill_random(int'($urandom_range(8, 1)));
      run_load(16'(prog.size()), 0, 3, 1'b0, (r == 2), 20);
    end

    // Largest accepted length.
    fill_random(int'(MAXW));
    run_load(16'(MAXW), 0, 0, 1'b0, 1'b0, 20);

    // Reset after the second byte of word 1, asserted together with start and rx_valid.
    fill_random(3);
    obs_addr.delete();
    obs_data.delete();
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    for (int k = 3; k >= 0; k--) send_byte(prog[0][8*k +: 8], 0);
    send_byte(prog[1][31:24], 0);
    send_byte(prog[1][23:16], 0);
    reset        = 1'b1;
    start        = 1'b1;
    bus.rx_valid = 1'b1;
    step();
    reset        = 1'b0;
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    check("abort_rx_ready", 32'(bus.rx_ready), 32'd0);
    check("abort_mem_we", 32'(bus.mem_we), 32'd0);
    check("abort_hold_cpu", 32'(hold_cpu), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_error", 32'(error), 32'd0);
    check("abort_mem_addr", bus.mem_addr, 32'd0);
    check("abort_mem_data", bus.mem_data, 32'd0);
    repeat (4) step();
    check("abort_idle_hold", 32'(hold_cpu), 32'd0);
    check("abort_write_count", 32'(obs_addr.size()), 32'd1);
    if (obs_addr.size() > 0) check("abort_first_write", obs_data[0], prog[0]);
    run_load(16'd3, 0, 2, 1'b0, 1'b0, 20);

    // Checksum cases: 01^02^03^04 = 04 is correct, 05 is not (ignored without the checksum build).
    prog.delete();
    prog.push_back(32'h0102_0304);
    run_load(16'd1, 0, 1, 1'b0, 1'b0, 20);
    run_load(16'd1, 0, 1, 1'b1, 1'b0, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: BASE_ADDR, 32'd0, byte address of first instruction word written.
REQ-002 Parameter: MAX_WORDS, 1024, largest accepted program length in words.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  begin a load; sampled only in IDLE or DONE.
REQ-006 Port: rx_valid  input  1  rx_data holds a valid byte.
REQ-007 Port: rx_data  input  8  incoming program byte stream.
REQ-008 Port: rx_ready  output  1  loader will accept a byte this cycle.
REQ-009 Port: mem_we  output  1  instruction-memory write enable (regWE).
REQ-010 Port: mem_addr  output  32  instruction-memory byte address.
REQ-011 Port: mem_data  output  32  instruction word to write.
REQ-012 Port: hold_cpu  output  1  high while loading; forces the fetch unit's write_pc low.
REQ-013 Port: done  output  1  load finished; sticky until next start or reset.
REQ-014 Port: error  output  1  load failed; sticky until next start or reset.

Function
REQ-015 FSM states SHALL be IDLE, HDR, DATA, WRITE, CSUM (macro only), DONE.
REQ-016 Byte handshake: byte consumed only on a clock edge where rx_valid && rx_ready; rx_valid without rx_ready SHALL be ignored.
REQ-017 IDLE/DONE: start=1 -> HDR next cycle; clears done, error, byte counter, word index, checksum.
REQ-018 start outside IDLE/DONE SHALL be ignored.
REQ-019 HDR: rx_ready=1; two bytes form word_count[15:0], first byte = bits 15:8.
REQ-020 HDR exit: word_count==0 -> CSUM/DONE with no writes; word_count>MAX_WORDS -> error=1, DONE, no writes; else DATA.
REQ-021 DATA: rx_ready=1; four bytes assembled big-endian (first byte -> bits 31:24); after the fourth accepted byte -> WRITE.
REQ-022 WRITE: rx_ready=0; mem_we=1 for exactly one cycle; mem_addr = BASE_ADDR + 4*word_index (mod 2^32); mem_data = assembled word.
REQ-023 WRITE exit: word_index increments; if new index == word_count -> CSUM/DONE, else DATA.
REQ-024 mem_we SHALL be 0 in every state except WRITE; mem_addr/mem_data hold last values outside WRITE.
REQ-025 hold_cpu SHALL be 1 in HDR, DATA, WRITE, CSUM; 0 in IDLE and DONE.
REQ-026 DONE: done=1, rx_ready=0, hold_cpu=0.
REQ-027 Per-word latency: 4 accepted bytes + 1 WRITE cycle; best-case full load = 2 + 5*word_count (+1 with checksum) accepted-byte/write cycles after start.

Reset
REQ-028 reset=1 at a clock edge SHALL force IDLE; rx_ready, mem_we, hold_cpu, done, error = 0; mem_addr, mem_data = 0; counters and checksum = 0.
REQ-029 reset mid-load SHALL abort at once; no further mem_we; words already written remain in memory.
REQ-030 reset SHALL take priority over start and rx_valid in the same cycle.

Configuration
REQ-031 Macro IMEM_LOADER_CHECKSUM_EN defined: running XOR of all data bytes (header excluded); after last WRITE (or zero-length header) enter CSUM, rx_ready=1, accept one byte; mismatch -> error=1; then DONE.
REQ-032 Macro undefined: no CSUM state; after last WRITE go straight to DONE; error only from REQ-020 oversize.

Verification
REQ-033 start, bytes 00 01 DE AD BE EF -> one mem_we pulse, mem_addr=0x00000000, mem_data=0xDEADBEEF, then done=1, hold_cpu=0.
REQ-034 BASE_ADDR=0x100, count=3, words 0x11111111/0x22222222/0x33333333 with rx_valid toggling every other cycle -> writes at 0x100, 0x104, 0x108 in order, no lost or duplicated bytes.
REQ-035 Header 0x0401 with MAX_WORDS=1024 -> error=1, done=1, mem_we never asserted.
REQ-036 reset asserted after second data byte of word 1 -> next cycle IDLE, all outputs 0, no mem_we; new start + full stream loads correctly.
REQ-037 Checksum macro defined: count=1, word 0x01020304, checksum byte 0x04 -> done=1, error=0; checksum byte 0x05 -> error=1.
REQ-038 Header 0x0000 -> done=1 within 3 cycles of last header byte, mem_we never asserted, error=0.
